// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall FSM, mult/div HI/LO interlock,
// branch flush priority and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_MulDiv,
  input  logic        ID_UsesHiLo,
  input  logic        EX_BranchTaken,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        MulDiv_Busy,
  output logic [15:0] Stall_Count
);

  localparam int unsigned MD_W  = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t            state;
  state_t            state_next;
  logic [MD_W-1:0]   md_cnt;
  logic              branch;
  logic              load_hazard;
  logic              md_hazard;
  logic              stall;
  logic              md_issue;

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Hazard detection, next state and pipeline control; reset forces the idle controls
  always_comb begin
    state_next   = state;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;

    branch      = EX_BranchTaken & ~reset;
    load_hazard = (state == RUN) & ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                  ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt)) & ~reset;
    md_hazard   = (md_cnt != '0) & (ID_MulDiv | ID_UsesHiLo) & ~reset;
    stall       = (load_hazard | md_hazard) & ~branch;
    md_issue    = ID_MulDiv & ~stall & ~branch & ~reset;

    case (state)
      RUN:     if (load_hazard && !branch) state_next = LDSTALL;
      LDSTALL: state_next = RUN;
      default: state_next = RUN;
    endcase

    if (branch) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  // HI/LO occupancy countdown; reloads on every issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               md_cnt <= '0;
    else if (md_issue)       md_cnt <= MD_W'(MULDIV_LAT);
    else if (md_cnt != '0)   md_cnt <= md_cnt - MD_W'(1);
  end

  assign MulDiv_Busy = (md_cnt != '0);

  // Stall cycle counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Stall_Count <= '0;
    else if (stall && (Stall_Count != {CNT_W{1'b1}}))
      Stall_Count <= Stall_Count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: vector table plus reset and saturation sequences.
module tb_hazard_control_unit;

  logic        clk;
  logic        reset;
  logic        mr;
  logic [4:0]  ert, rs, rt;
  logic        md, hl, br;
  logic        pc_w, ifid_w, bub, flush, busy;
  logic [15:0] cnt;

  logic        s_reset;
  logic        s_pc_w, s_ifid_w, s_bub, s_flush, s_busy;
  logic [15:0] s_cnt;

  int checks = 0;
  int errors = 0;

  hazard_control_unit dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(mr), .ID_EX_Rt(ert), .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .ID_MulDiv(md), .ID_UsesHiLo(hl), .EX_BranchTaken(br),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w), .ID_EX_Bubble(bub),
    .IF_ID_Flush(flush), .MulDiv_Busy(busy), .Stall_Count(cnt)
  );

  // Long-latency instance used only to reach counter saturation quickly
  hazard_control_unit #(.MULDIV_LAT(15)) dut_sat (
    .clk(clk), .reset(s_reset),
    .ID_EX_MemRead(1'b1), .ID_EX_Rt(5'd5), .IF_ID_Rs(5'd5), .IF_ID_Rt(5'd0),
    .ID_MulDiv(1'b1), .ID_UsesHiLo(1'b0), .EX_BranchTaken(1'b0),
    .PC_Write(s_pc_w), .IF_ID_Write(s_ifid_w), .ID_EX_Bubble(s_bub),
    .IF_ID_Flush(s_flush), .MulDiv_Busy(s_busy), .Stall_Count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy}
  localparam logic [4:0] F_N   = 5'b11000;
  localparam logic [4:0] F_NB  = 5'b11001;
  localparam logic [4:0] F_S   = 5'b00100;
  localparam logic [4:0] F_SB  = 5'b00101;
  localparam logic [4:0] F_BR  = 5'b11110;
  localparam logic [4:0] F_BRB = 5'b11111;

  typedef struct packed {
    logic        mr;
    logic [4:0]  ert;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        md;
    logic        hl;
    logic        br;
    logic [4:0]  flags;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic m, input logic [4:0] e, input logic [4:0] s,
                              input logic [4:0] t, input logic d, input logic h,
                              input logic b, input logic [4:0] f, input logic [15:0] c);
    vec_t v;
    v.mr = m; v.ert = e; v.rs = s; v.rt = t; v.md = d; v.hl = h; v.br = b;
    v.flags = f; v.cnt = c;
    return v;
  endfunction

  task automatic set_in(input logic m, input logic [4:0] e, input logic [4:0] s,
                        input logic [4:0] t, input logic d, input logic h, input logic b);
    mr = m; ert = e; rs = s; rt = t; md = d; hl = h; br = b;
  endtask

  task automatic check(input string name, input logic [4:0] f, input logic [15:0] c);
    logic [20:0] got;
    logic [20:0] exp;
    got = {pc_w, ifid_w, bub, flush, busy, cnt};
    exp = {f, c};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%b count=%0d, expected flags=%b count=%0d",
               name, got[20:16], got[15:0], exp[20:16], exp[15:0]);
    end
  endtask

  task automatic check_sat(input string name, input logic [15:0] c);
    checks++;
    if (s_cnt !== c) begin
      errors++;
      $display("FAIL %s: got count=%0d, expected count=%0d", name, s_cnt, c);
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, F_N,   0);
    tbl[1]  = mk(1, 5, 5, 0, 0, 0, 0, F_S,   0);
    tbl[2]  = mk(1, 5, 5, 0, 0, 0, 0, F_N,   1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, F_N,   1);
    tbl[4]  = mk(1, 7, 3, 7, 0, 0, 0, F_S,   1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, F_N,   2);
    tbl[6]  = mk(1, 5, 5, 0, 0, 0, 1, F_BR,  2);
    tbl[7]  = mk(1, 5, 5, 0, 0, 0, 0, F_S,   2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, F_N,   3);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, F_N,   3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, F_NB,  3);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, F_SB,  3);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, F_SB,  4);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, F_SB,  5);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, F_N,   6);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, F_N,   6);
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, F_N,   6);
    tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, F_SB,  6);
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 1, F_BRB, 7);
    tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, F_SB,  7);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 0, F_SB,  8);
    tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, F_N,   9);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, F_NB,  9);
    tbl[23] = mk(1, 5, 5, 0, 0, 1, 0, F_SB,  9);
    tbl[24] = mk(1, 5, 5, 0, 0, 1, 0, F_SB,  10);
    tbl[25] = mk(0, 0, 0, 0, 0, 1, 0, F_SB,  11);
    tbl[26] = mk(0, 0, 0, 0, 0, 1, 0, F_N,   12);

    // Reset held with hazardous inputs: controls must stay idle
    reset = 1'b1;
    s_reset = 1'b1;
    set_in(1, 5, 5, 0, 1, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("reset_hazard_inputs", F_N, 0);
    br = 1'b1; #1;
    check("reset_branch_input", F_N, 0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      set_in(tbl[i].mr, tbl[i].ert, tbl[i].rs, tbl[i].rt, tbl[i].md, tbl[i].hl, tbl[i].br);
      #2;
      check($sformatf("vec%0d", i), tbl[i].flags, tbl[i].cnt);
    end

    // Reset in the middle of a mult/div countdown
    @(negedge clk); set_in(0, 0, 0, 0, 1, 0, 0); #2;
    check("md_issue", F_N, 12);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0); #2;
    check("md_busy_1", F_NB, 12);
    @(negedge clk); #2;
    check("md_busy_2", F_NB, 12);
    hl = 1'b1; reset = 1'b1; #1;
    check("rst_mid_md", F_N, 0);
    @(negedge clk); reset = 1'b0; #2;
    check("post_rst_md", F_N, 0);

    // Reset in the middle of a load-use stall
    @(negedge clk); set_in(1, 5, 5, 0, 0, 0, 0); #2;
    check("post_rst_load", F_S, 0);
    @(negedge clk); reset = 1'b1; #1;
    check("rst_mid_ld", F_N, 0);
    @(negedge clk); reset = 1'b0; #2;
    check("post_rst_ld", F_S, 0);

    // Saturation: 15 of every 16 cycles stall after the first
    @(negedge clk); s_reset = 1'b0;
    repeat (1601) @(posedge clk);
    #1;
    check_sat("sat_partial", 16'd1501);
    repeat (68900) @(posedge clk);
    #1;
    check_sat("sat_full", 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
